// File: rtl/ysyx_040729_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one fetch request
// outstanding at a time, and buffers {pc, instruction} pairs in a small FIFO
// in front of decode. Redirects from execute re-steer fetch, flush the FIFO
// and mark any in-flight response as stale.
module ysyx_040729_ifu #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction memory request channel
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  // instruction memory response channel (always accepted)
  input  logic                  ifu_rsp_valid,
  input  logic [INST_WIDTH-1:0] ifu_rsp_data,
  // control-flow re-steer from execute
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  // decode side
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    discard;
  logic                    req_valid_q;

  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_after;
  logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0]   inst_mem [DEPTH];

  logic                    handshake;
  logic                    push;
  logic                    pop;

  assign handshake = (state == S_REQ) && ifu_req_ready;
  // A stale (discarded) or redirected response never enters the FIFO.
  assign push      = (state == S_WAIT) && ifu_rsp_valid && !discard && !redirect_valid;
  // A redirect voids any pop in its cycle; the whole FIFO is flushed instead.
  assign pop       = inst_valid && inst_ready && !redirect_valid;

  // FIFO occupancy after this cycle's push/pop, used to decide whether to refetch.
  always_comb begin
    // NOTE: default first so every path assigns count_after and no latch is inferred.
    count_after = count;
    if (push && !pop) begin
      count_after = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_after = count - CNT_W'(1);
    end
  end

  // Fetch FSM: request sequencing, fetch PC tracking and stale-response marking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state       <= S_IDLE;
      next_pc     <= RESET_PC;
      req_addr    <= '0;
      discard     <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            // Only the PC moves; the flushed FIFO lets the next cycle issue it.
            next_pc <= redirect_pc;
          end else if (count < FULL) begin
            state       <= S_REQ;
            req_addr    <= next_pc;
            req_valid_q <= 1'b1;
          end
        end

        S_REQ: begin
          if (redirect_valid) begin
            // The request cannot be withdrawn, so its response is marked stale.
            next_pc <= redirect_pc;
            discard <= 1'b1;
          end else if (handshake && !discard) begin
            // A request already marked stale must not advance the redirected PC.
            next_pc <= req_addr + ADDR_WIDTH'(4);
          end
          if (handshake) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end

        S_WAIT: begin
          if (ifu_rsp_valid) begin
            // The outstanding response has arrived; nothing is left to discard.
            discard <= 1'b0;
            if (redirect_valid) begin
              next_pc     <= redirect_pc;
              state       <= S_REQ;
              req_addr    <= redirect_pc;
              req_valid_q <= 1'b1;
            end else if (count_after < FULL) begin
              state       <= S_REQ;
              req_addr    <= next_pc;
              req_valid_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (redirect_valid) begin
            next_pc <= redirect_pc;
            discard <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_after;
    end
  end

  // FIFO storage write port.
  // NOTE: storage is not reset; entries are only observable once count says
  // they were written, and the outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_addr;
      inst_mem[wr_ptr] <= ifu_rsp_data;
    end
  end

  assign ifu_req_valid = req_valid_q;
  assign ifu_req_addr  = req_addr;
  assign inst_valid    = (count != '0);
  assign instruction   = inst_valid ? inst_mem[rd_ptr] : '0;
  assign inst_pc       = inst_valid ? pc_mem[rd_ptr]   : '0;

endmodule

// File: doc/ysyx_040729_ifu.md
# ysyx_040729_ifu

Instruction fetch unit that sits directly upstream of the instruction decoder. It owns the fetch PC, issues single-outstanding fetch requests to the instruction memory port, and buffers returned instructions in a small FIFO. It presents `{pc, instruction}` to decode with a valid/ready handshake. Control-flow redirects (branch, jump, ecall, mret) from the execute stage re-steer fetch and squash stale instructions.

## Interface
- `ADDR_WIDTH`, 64, PC and fetch address width
- `INST_WIDTH`, 32, instruction width
- `RESET_PC`, 64'h8000_0000, first fetch address after reset
- `DEPTH`, 2, instruction FIFO entries (power of two, ≥2)

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ifu_req_valid` out 1: fetch request valid.
- `ifu_req_ready` in 1: memory accepts the request.
- `ifu_req_addr` out ADDR_WIDTH: fetch address.
- `ifu_rsp_valid` in 1: fetch data returned. Always accepted; there is no ready.
- `ifu_rsp_data` in INST_WIDTH: fetched instruction.
- `redirect_valid` in 1: re-steer fetch.
- `redirect_pc` in ADDR_WIDTH: new fetch PC.
- `inst_valid` out 1: FIFO head valid toward decode.
- `inst_ready` in 1: decode consumes the head.
- `instruction` out INST_WIDTH: head instruction.
- `inst_pc` out ADDR_WIDTH: PC of the head instruction.

## Operation
- Registers:
  - `next_pc` resets to `RESET_PC`.
  - `req_addr`.
  - `discard` flag.
  - FIFO of `{pc, inst}` with read and write pointers plus a count in 0..DEPTH.
- FSM states:
  - **IDLE**: `ifu_req_valid`=0. Moves to REQ when `count<DEPTH`, loading `req_addr<=next_pc`.
  - **REQ**: `ifu_req_valid`=1 with `ifu_req_addr=req_addr`. Address and valid stay stable until `ifu_req_ready`. On handshake, go to WAIT.
  - **WAIT**: waits for `ifu_rsp_valid`. On response:
    - If `count<DEPTH` after this cycle's push/pop, go straight to REQ, loading `req_addr<=next_pc`.
    - Otherwise go to IDLE.
- `next_pc` update: on the REQ handshake with no redirect that cycle, `next_pc<=req_addr+4`. Arithmetic is modulo 2^ADDR_WIDTH and wrap-around is allowed.
- Response in WAIT:
  - `discard`=0: push `{req_addr, ifu_rsp_data}`.
  - `discard`=1: drop the response and clear `discard`.
- Responses outside WAIT are ignored.
- Redirect has priority over every other event in its cycle:
  - `next_pc<=redirect_pc`.
  - FIFO flushed (count=0, pointers reset). A pop in the same cycle is void.
  - In REQ: the request is not withdrawn. `discard<=1`, so its response is later dropped. This also applies when the handshake happens in the same cycle.
  - In WAIT with no response this cycle: `discard<=1`.
  - In WAIT with a response this cycle: the response is dropped, `discard` stays 0, and the FSM goes to REQ with `req_addr<=redirect_pc`.
  - In IDLE: only `next_pc` updates; the next request uses `redirect_pc`.
- Redirect while `discard` is already 1: `next_pc` is overwritten by the newest `redirect_pc` and `discard` stays 1. At most one request is outstanding.
- Decode side:
  - `inst_valid=(count!=0)`; `instruction` and `inst_pc` show the FIFO head.
  - Pop on `inst_valid&&inst_ready&&!redirect_valid`.
  - Push and pop in the same cycle leave count unchanged.
- Overflow cannot occur: issue requires `count<DEPTH`, and the only push is the single outstanding response.

## Timing
- Reset, asynchronous: FSM=IDLE, `next_pc=RESET_PC`, `discard`=0, count=0. Outputs: `ifu_req_valid`=0, `inst_valid`=0; `ifu_req_addr`, `instruction` and `inst_pc`=0.
- First `ifu_req_valid` comes one cycle after `rst_n` deasserts (IDLE→REQ), with address `RESET_PC`.
- Response at edge t → `inst_valid`=1 from cycle t+1. There is no combinational path from `ifu_rsp_*` to `inst_*`.
- Back-to-back throughput with `ifu_req_ready`=1 and a 1-cycle memory: one instruction every 2 cycles (REQ, WAIT, REQ...).
- Redirect at cycle t → `inst_valid`=0 at t+1. The first new instruction appears no earlier than t+3 (1-cycle memory).
- Reset asserted mid-transaction abandons the outstanding request. After release, any late response is ignored, because the FSM is not in WAIT until a new handshake.

## Test plan
- **Reset / first fetch:** release `rst_n`, `ifu_req_ready`=1, return 32'h00000413 next cycle → `ifu_req_addr`=0x8000_0000; `inst_valid`=1 with `inst_pc`=0x8000_0000, `instruction`=32'h00000413; next request address 0x8000_0004.
- **Backpressure:** hold `inst_ready`=0 → two instructions fetched (PCs 0x…000, 0x…004), then `ifu_req_valid` stays 0. Raise `inst_ready` for 1 cycle → head pops and a request for 0x…008 issues.
- **Redirect during WAIT:** `redirect_pc`=0x8000_0100 while a response is outstanding → that response is dropped, the FIFO is empty, and the next request address is 0x8000_0100.
- **Redirect in the same cycle as a response:** response dropped; the request for 0x8000_0100 issues the next cycle; `discard` stays 0.
- **Stalled request:** `ifu_req_ready`=0 for 5 cycles with a redirect in cycle 2 → address stays stable; the accepted request's response is discarded; then a fetch of `redirect_pc`.
- **Wrap and async reset:** `redirect_pc`=64'hFFFF_FFFF_FFFF_FFFC → following fetch address 0. Assert `rst_n`=0 mid-WAIT → all outputs clear immediately.
